// File: rtl/rm_list_sequencer_if.sv
// Handshake bundle between the microcoded control FSM (master) and the
// LDM/STM register-list sequencer (slave).
interface rm_list_sequencer_if #(parameter int AW = 32);
    logic          start;
    logic [15:0]   reg_list;
    logic [AW-1:0] base_addr;
    logic          u_bit;
    logic          p_bit;
    logic          step;
    logic          mem_ready;
    logic          abort;
    logic          busy;
    logic          done;
    logic [3:0]    reg_idx;
    logic [AW-1:0] xfer_addr;
    logic [AW-1:0] wb_addr;
    logic [4:0]    count;

    modport master (
        output start, reg_list, base_addr, u_bit, p_bit, step, mem_ready, abort,
        input  busy, done, reg_idx, xfer_addr, wb_addr, count
    );

    modport slave (
        input  start, reg_list, base_addr, u_bit, p_bit, step, mem_ready, abort,
        output busy, done, reg_idx, xfer_addr, wb_addr, count
    );
endinterface

// File: rtl/rm_list_sequencer.sv
// Register-list sequencer for LDM/STM: walks the list lowest register first,
// emitting register index and ascending word address per beat plus base write-back.
module rm_list_sequencer #(
    parameter int AW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    rm_list_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [15:0]   pending;
    logic          busy_q;
    logic          done_q;
    logic [3:0]    reg_idx_q;
    logic [AW-1:0] xfer_addr_q;
    logic [AW-1:0] wb_addr_q;
    logic [4:0]    count_q;

    logic [4:0]    list_n;
    logic [AW-1:0] four_n;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] wb_calc;
    logic [15:0]   pending_next;
    logic          accept;

    // Lowest set bit wins, so the scan runs downward and keeps overwriting.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

    // The block always ascends from the lowest address; only the start point
    // and the write-back value depend on the addressing mode.
    always_comb begin
        list_n = popcount16(bus.reg_list);
        four_n = AW'(list_n) << 2;
        unique case ({bus.u_bit, bus.p_bit})
            2'b10:   begin first_addr = bus.base_addr;                  wb_calc = bus.base_addr + four_n; end
            2'b11:   begin first_addr = bus.base_addr + AW'(4);         wb_calc = bus.base_addr + four_n; end
            2'b00:   begin first_addr = bus.base_addr - four_n + AW'(4); wb_calc = bus.base_addr - four_n; end
            default: begin first_addr = bus.base_addr - four_n;         wb_calc = bus.base_addr - four_n; end
        endcase
        accept       = (state == RUN) && bus.step && bus.mem_ready;
        pending_next = pending & ~(16'd1 << reg_idx_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            reg_idx_q   <= '0;
            xfer_addr_q <= '0;
            wb_addr_q   <= '0;
            count_q     <= '0;
        end else if (bus.abort) begin
            state   <= IDLE;
            pending <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        pending     <= bus.reg_list;
                        count_q     <= list_n;
                        wb_addr_q   <= wb_calc;
                        xfer_addr_q <= {first_addr[AW-1:2], 2'b00};
                        reg_idx_q   <= lowest_set(bus.reg_list);
                        busy_q      <= 1'b1;
                        if (bus.reg_list != 16'd0) begin
                            state <= RUN;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // The final beat leaves index and address on the last register.
                    if (accept) begin
                        pending <= pending_next;
                        if (pending_next == 16'd0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            reg_idx_q   <= lowest_set(pending_next);
                            xfer_addr_q <= xfer_addr_q + AW'(4);
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.reg_idx   = reg_idx_q;
    assign bus.xfer_addr = xfer_addr_q;
    assign bus.wb_addr   = wb_addr_q;
    assign bus.count     = count_q;

endmodule
